uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit FIFO write port between NUM_REQ byte-stream requesters, such as the CPU bus slave and a debug monitor. A granted requester keeps the port until it sends a byte flagged last, so its packets never interleave with another requester's. An idle-timeout releases the grant if the owner stalls. The block sits between the requesters and the tx FIFO (din/wr_en/full) in front of the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing the single UART tx FIFO write port between
// NUM_REQ byte-stream requesters. A granted requester owns the port until
// it sends a byte flagged last, so packets never interleave. An owner that
// stops presenting bytes (while the FIFO has room) for TIMEOUT_CYCLES
// cycles loses the grant.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      per-requester byte valid              [NUM_REQ]
//   req_data       per-requester byte, req i at [8i+7:8i] [8*NUM_REQ]
//   req_last       byte is the last of its packet        [NUM_REQ]
//   req_ready      byte accepted when valid & ready      [NUM_REQ]
//   fifo_din       tx FIFO write data                    [8]
//   fifo_wr_en     tx FIFO write strobe
//   fifo_full      tx FIFO full
//   busy           grant held
//   grant_id       current owner, valid while busy       [IDW]
//   timeout_pulse  one-cycle pulse after a forced release
//   timeout_count  saturating count of forced releases   [16]
//
// Optional feature macro: UART_ARB_STATS_EN
//   defined   : timeout_count counts forced releases, saturating at 16'hFFFF
//   undefined : timeout_count is tied to 0 and no counter is built
//
// req_ready, fifo_wr_en and fifo_din are combinational from the current
// owner's inputs and fifo_full so a byte moves in the cycle it is offered.

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned IDW            = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             fifo_din,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   timeout_pulse,
    output logic [15:0]            timeout_count
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               timeout_pulse_q, timeout_pulse_d;

    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_data;
    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic [IDW-1:0]     owner_inc;
    logic [2*NUM_REQ-1:0] valid_rot;
    logic               xfer;
    int                 pick_sum;
    int                 inc_sum;

    // Mux the owner's request lines.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner_q == IDW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    // First valid requester scanning from rr_ptr; rotating the doubled
    // vector puts rr_ptr at bit 0 so the scan is a plain priority pick.
    always_comb begin
        valid_rot  = {req_valid, req_valid} >> rr_ptr_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!pick_found && valid_rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = int'(rr_ptr_q) + k;
                if (pick_sum >= int'(NUM_REQ)) begin
                    pick_sum = pick_sum - int'(NUM_REQ);
                end
                pick_idx = IDW'(pick_sum);
            end
        end
    end

    // (owner + 1) mod NUM_REQ, the pointer after any release.
    always_comb begin
        inc_sum = int'(owner_q) + 1;
        if (inc_sum >= int'(NUM_REQ)) begin
            inc_sum = 0;
        end
        owner_inc = IDW'(inc_sum);
    end

    // State and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            idle_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            idle_cnt_q      <= idle_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    // Next-state and FIFO-port logic.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        idle_cnt_d      = idle_cnt_q;
        timeout_pulse_d = 1'b0;
        req_ready       = '0;
        xfer            = 1'b0;
        fifo_din        = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end

            ST_LOCKED: begin
                fifo_din = own_data;
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    if (owner_q == IDW'(i)) begin
                        req_ready[i] = !fifo_full;
                    end
                end
                xfer = own_valid && !fifo_full;

                if (xfer) begin
                    idle_cnt_d = '0;
                    if (own_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end else if (!fifo_full) begin
                    // Owner idle with room in the FIFO; back-pressure holds the count.
                    if (TO_EN && (idle_cnt_q == CNT_W'(TO_LAST))) begin
                        state_d         = ST_IDLE;
                        rr_ptr_d        = owner_inc;
                        timeout_pulse_d = 1'b1;
                        idle_cnt_d      = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_wr_en    = xfer;
    assign busy          = (state_q == ST_LOCKED);
    assign grant_id      = owner_q;
    assign timeout_pulse = timeout_pulse_q;

`ifdef UART_ARB_STATS_EN
    logic [15:0] timeout_cnt_q;

    // Forced-release counter, saturating; aligned with timeout_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_q <= 16'h0000;
        end else if (timeout_pulse_d && (timeout_cnt_q != 16'hFFFF)) begin
            timeout_cnt_q <= timeout_cnt_q + 16'h0001;
        end
    end

    assign timeout_count = timeout_cnt_q;
`else
    assign timeout_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, a per-cycle reference
// model compared at the falling edge, and directed scenario checks.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [7:0]    fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full;
    logic          busy;
    logic [1:0]    grant_id;
    logic          timeout_pulse;
    logic [15:0]   timeout_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO),
        .IDW(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_pulse(timeout_pulse),
        .timeout_count(timeout_count)
    );

    // Requester sources: {last, byte} entries per requester.
    logic [8:0] src_mem [NR][64];
    int         head [NR];
    int         tail [NR];
    logic       stall [NR];
    logic       rst_v;
    logic       full_v;

    // Reference model: holder -1 means nobody owns the port.
    int   m_hold;
    int   m_ptr;
    int   m_idle;
    int   m_tcnt;
    logic m_pulse;

    logic [7:0] wlog [$];
    int         wown [$];
    int         wcyc [$];
    int         cyc;

    int n_vec;
    int n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        src_mem[r][tail[r]] = {l, b};
        tail[r]++;
    endtask

    function automatic logic bit_of(input logic [NR-1:0] v, input int i);
        logic [NR-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic model_check();
        logic          e_busy;
        logic          e_wr;
        logic [NR-1:0] e_ready;
        logic [31:0]   sh;
        logic          n_pulse;
        int            r;
        logic          found;
        if (!rst_n) begin
            m_hold = -1; m_ptr = 0; m_idle = 0; m_tcnt = 0; m_pulse = 1'b0;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_grant", 32'(grant_id), 32'd0);
            chk("rst_pulse", 32'(timeout_pulse), 32'd0);
            chk("rst_tcount", 32'(timeout_count), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_wr", 32'(fifo_wr_en), 32'd0);
        end else begin
            e_busy  = (m_hold >= 0);
            e_ready = '0;
            e_wr    = 1'b0;
            if (e_busy) begin
                if (!fifo_full) e_ready = NR'(1) << m_hold;
                e_wr = bit_of(req_valid, m_hold) && !fifo_full;
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("pulse", 32'(timeout_pulse), 32'(m_pulse));
`ifdef UART_ARB_STATS_EN
            chk("tcount", 32'(timeout_count), 32'(m_tcnt));
`else
            chk("tcount", 32'(timeout_count), 32'd0);
`endif
            chk("ready", 32'(req_ready), 32'(e_ready));
            chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
            if (e_busy) chk("grant", 32'(grant_id), 32'(m_hold));
            if (e_wr) begin
                sh = req_data >> (8 * m_hold);
                chk("din", 32'(fifo_din), 32'(sh[7:0]));
            end

            n_pulse = 1'b0;
            if (m_hold < 0) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    r = (m_ptr + k) % NR;
                    if (!found && bit_of(req_valid, r)) begin
                        found  = 1'b1;
                        m_hold = r;
                        m_idle = 0;
                    end
                end
            end else if (e_wr) begin
                if (bit_of(req_last, m_hold)) begin
                    m_ptr  = (m_hold + 1) % NR;
                    m_hold = -1;
                end else begin
                    m_idle = 0;
                end
            end else if (!fifo_full) begin
                if (TO != 0 && m_idle == TO - 1) begin
                    m_ptr   = (m_hold + 1) % NR;
                    m_hold  = -1;
                    n_pulse = 1'b1;
                    m_idle  = 0;
                    if (m_tcnt < 65535) m_tcnt++;
                end else begin
                    m_idle++;
                end
            end
            m_pulse = n_pulse;
        end
    endtask

    // One clock: drive after the rising edge, check at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        rst_n     = rst_v;
        fifo_full = full_v;
        for (int i = 0; i < NR; i++) begin
            logic v;
            v = (head[i] < tail[i]) && !stall[i];
            req_valid[i]       = v;
            req_data[8*i +: 8] = v ? src_mem[i][head[i]][7:0] : 8'h00;
            req_last[i]        = v && src_mem[i][head[i]][8];
        end
        @(negedge clk);
        model_check();
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) head[i]++;
        end
        if (fifo_wr_en) begin
            wlog.push_back(fifo_din);
            wown.push_back(int'(grant_id));
            wcyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_v  = 1'b0;
        full_v = 1'b0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0; tail[i] = 0; stall[i] = 1'b0;
        end
        step();
        step();
        rst_v = 1'b1;
        wlog.delete(); wown.delete(); wcyc.delete();
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("drain", 32'(wlog.size()), 32'(n));
    endtask

    int viol, wr_seen, pulse_seen, pk, bcnt;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; rst_v = 1'b0; full_v = 1'b0; fifo_full = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        m_hold = -1; m_ptr = 0; m_idle = 0; m_tcnt = 0; m_pulse = 1'b0;

        // Reset, then a single one-byte request from requester 2.
        do_reset();
        push(2, 8'h41, 1'b1);
        step();
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_wr", 32'(fifo_wr_en), 32'd0);
        step();
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_grant", 32'(grant_id), 32'd2);
        chk("single_wr", 32'(fifo_wr_en), 32'd1);
        chk("single_din", 32'(fifo_din), 32'h41);
        step();
        chk("single_release", 32'(busy), 32'd0);

        // Round robin with everyone continuously valid.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            push(r, 8'(8'h10 * r), 1'b1);
            push(r, 8'(8'h10 * r + 1), 1'b1);
        end
        run_until(8, 40);
        chk("rr_own0", 32'(wown[0]), 32'd0);
        chk("rr_own1", 32'(wown[1]), 32'd1);
        chk("rr_own2", 32'(wown[2]), 32'd2);
        chk("rr_own3", 32'(wown[3]), 32'd3);
        chk("rr_own4", 32'(wown[4]), 32'd0);
        for (int k = 0; k < 4; k++) chk("rr_gap", 32'(wcyc[k+1] - wcyc[k]), 32'd2);

        // Packet atomicity: req0 "ABC" while req1 waits.
        do_reset();
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        push(1, 8'h58, 1'b1);
        viol = 0;
        for (int k = 0; k < 30 && wlog.size() < 4; k++) begin
            step();
            if (busy && grant_id == 2'd0 && req_ready[1]) viol++;
        end
        chk("atom_count", 32'(wlog.size()), 32'd4);
        chk("atom_b0", 32'(wlog[0]), 32'h41);
        chk("atom_b1", 32'(wlog[1]), 32'h42);
        chk("atom_b2", 32'(wlog[2]), 32'h43);
        chk("atom_b3", 32'(wlog[3]), 32'h58);
        chk("atom_ready1", 32'(viol), 32'd0);

        // Back-pressure for 2000 cycles mid-packet.
        do_reset();
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
        run_until(1, 10);
        full_v = 1'b1;
        wr_seen = 0; pulse_seen = 0;
        for (int k = 0; k < 2000; k++) begin
            step();
            if (fifo_wr_en) wr_seen++;
            if (timeout_pulse) pulse_seen++;
        end
        chk("bp_still_busy", 32'(busy), 32'd1);
        full_v = 1'b0;
        run_until(3, 10);
        chk("bp_wr", 32'(wr_seen), 32'd0);
        chk("bp_pulse", 32'(pulse_seen), 32'd0);
        chk("bp_b1", 32'(wlog[1]), 32'h51);
        chk("bp_b2", 32'(wlog[2]), 32'h52);

        // Owner stalls mid-packet until the idle timeout fires.
        do_reset();
        push(0, 8'h54, 1'b0); push(0, 8'h55, 1'b1);
        push(1, 8'h56, 1'b1);
        run_until(1, 10);
        stall[0] = 1'b1;
        pk = 0; bcnt = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (busy) bcnt++;
            if (timeout_pulse) begin
                pk = k;
                break;
            end
        end
        chk("to_pulse_cycle", 32'(pk), 32'd1025);
        chk("to_busy_cycles", 32'(bcnt), 32'd1024);
        chk("to_released", 32'(busy), 32'd0);
`ifdef UART_ARB_STATS_EN
        chk("to_count", 32'(timeout_count), 32'd1);
`else
        chk("to_count", 32'(timeout_count), 32'd0);
`endif
        stall[0] = 1'b0;
        run_until(2, 10);
        chk("to_next_owner", 32'(wown[1]), 32'd1);
        chk("to_next_byte", 32'(wlog[1]), 32'h56);
        run_until(3, 10);
        chk("to_resume_byte", 32'(wlog[2]), 32'h55);

        // Asynchronous reset in the middle of requester 2's packet.
        do_reset();
        push(1, 8'h4B, 1'b1);
        run_until(1, 10);
        push(2, 8'h4C, 1'b0); push(2, 8'h4D, 1'b1);
        run_until(2, 10);
        rst_v = 1'b0;
        step();
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr", 32'(fifo_wr_en), 32'd0);
        push(0, 8'h4E, 1'b1);
        push(3, 8'h5A, 1'b1);
        rst_v = 1'b1;
        run_until(5, 20);
        chk("arst_first_owner", 32'(wown[2]), 32'd0);
        chk("arst_b2", 32'(wlog[2]), 32'h4E);
        chk("arst_b3", 32'(wlog[3]), 32'h4D);
        chk("arst_b4", 32'(wlog[4]), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
